usb_frame_rx: RTL and testbench

USB_FRAME_RX -- requirements
Module: usb_frame_rx

---
 rtl/usb_frame_rx.sv | 164 ++++++++++++++++
 tb/tb_usb_frame_rx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_frame_rx.sv
// USB receive-path frame parser: SOF, LEN, payload, optional CHK byte, with timeout.
// Define USB_FRAME_CHK_EN to compile in the trailing XOR checksum byte and its CHK state.
module usb_frame_rx #(
  parameter logic [7:0] SOF         = 8'hA5,
  parameter int         TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        itvalid,
  output logic        itready,
  input  logic [7:0]  itdata,
  output logic        otvalid,
  input  logic        otready,
  output logic [7:0]  otdata,
  output logic        otlast,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
);

`ifdef USB_FRAME_CHK_EN
  typedef enum logic [1:0] {HUNT, LEN, PAYLOAD, CHK} state_t;
  logic [7:0] chk_q, chk_d;
`else
  typedef enum logic [1:0] {HUNT, LEN, PAYLOAD} state_t;
`endif

  localparam logic [15:0] TMO_LIM = 16'(TIMEOUT_CYC);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] tmo_q, tmo_d, tmo_inc;
  logic        otvalid_q, otvalid_d, otlast_q, otlast_d;
  logic [7:0]  otdata_q, otdata_d;
  logic        ok_q, ok_d, err_q, err_d;
  logic [1:0]  code_q, code_d;
  logic [15:0] fcnt_q, fcnt_d, ecnt_q, ecnt_d;
  logic        accept, timeout;

  assign itready   = (state_q == PAYLOAD) ? (~otvalid_q | otready) : 1'b1;
  assign accept    = itvalid & itready;
  assign tmo_inc   = tmo_q + 16'd1;
  assign timeout   = (state_q != HUNT) && !itvalid && (tmo_inc == TMO_LIM);

  assign otvalid   = otvalid_q;
  assign otdata    = otdata_q;
  assign otlast    = otlast_q;
  assign frame_ok  = ok_q;
  assign frame_err = err_q;
  assign err_code  = code_q;
  assign frame_cnt = fcnt_q;
  assign err_cnt   = ecnt_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    otvalid_d = otvalid_q;
    otdata_d  = otdata_q;
    otlast_d  = otlast_q;
    ok_d      = 1'b0;
    err_d     = 1'b0;
    code_d    = 2'b00;
`ifdef USB_FRAME_CHK_EN
    chk_d     = chk_q;
`endif
    if (otvalid_q && otready) begin
      otvalid_d = 1'b0;
      otlast_d  = 1'b0;
    end
    // Any presented byte (accepted or backpressured) restarts the idle count.
    if (state_q == HUNT || itvalid) tmo_d = 16'd0;
    else                            tmo_d = tmo_inc;

    case (state_q)
      HUNT: if (accept && itdata == SOF) state_d = LEN;
      LEN: if (accept) begin
        if (itdata == 8'd0) begin
          err_d   = 1'b1;
          code_d  = 2'b01;
          state_d = HUNT;
        end else begin
          cnt_d   = itdata;
`ifdef USB_FRAME_CHK_EN
          chk_d   = itdata;
`endif
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: if (accept) begin
        otvalid_d = 1'b1;
        otdata_d  = itdata;
        otlast_d  = (cnt_q == 8'd1);
        cnt_d     = cnt_q - 8'd1;
`ifdef USB_FRAME_CHK_EN
        chk_d     = chk_q ^ itdata;
        if (cnt_q == 8'd1) state_d = CHK;
`else
        if (cnt_q == 8'd1) begin
          ok_d    = 1'b1;
          state_d = HUNT;
        end
`endif
      end
`ifdef USB_FRAME_CHK_EN
      CHK: if (accept) begin
        if (itdata == chk_q) ok_d = 1'b1;
        else begin
          err_d  = 1'b1;
          code_d = 2'b10;
        end
        state_d = HUNT;
      end
`endif
      default: state_d = HUNT;
    endcase

    if (timeout) begin
      err_d   = 1'b1;
      code_d  = 2'b11;
      state_d = HUNT;
      tmo_d   = 16'd0;
    end

    fcnt_d = fcnt_q + {15'd0, ok_d};
    ecnt_d = (err_d && ecnt_q != 16'hFFFF) ? ecnt_q + 16'd1 : ecnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= HUNT;
      cnt_q     <= 8'd0;
      tmo_q     <= 16'd0;
      otvalid_q <= 1'b0;
      otdata_q  <= 8'd0;
      otlast_q  <= 1'b0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= 2'b00;
      fcnt_q    <= 16'd0;
      ecnt_q    <= 16'd0;
`ifdef USB_FRAME_CHK_EN
      chk_q     <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      otvalid_q <= otvalid_d;
      otdata_q  <= otdata_d;
      otlast_q  <= otlast_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
      code_q    <= code_d;
      fcnt_q    <= fcnt_d;
      ecnt_q    <= ecnt_d;
`ifdef USB_FRAME_CHK_EN
      chk_q     <= chk_d;
`endif
    end
  end

endmodule

// File: tb/tb_usb_frame_rx.sv
// Randomized bench for usb_frame_rx: queue-based frame model, directed vectors, timeout and reset cases.
module tb_usb_frame_rx;
  logic        clk, rst;
  logic        itvalid, itready, otvalid, otready, otlast;
  logic [7:0]  itdata, otdata;
  logic        frame_ok, frame_err;
  logic [1:0]  err_code;
  logic [15:0] frame_cnt, err_cnt;

  usb_frame_rx #(.SOF(8'hA5), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .itvalid(itvalid), .itready(itready), .itdata(itdata),
    .otvalid(otvalid), .otready(otready), .otdata(otdata), .otlast(otlast),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  int total = 0;
  int bad   = 0;
  int rdy_mode = 1;        // 0 always ready, 1 random, 2 stalled
  bit gaps = 0;
  logic [8:0]  outq[$];    // {last, data} expected on the payload stream
  int          evq[$];     // 0 = frame_ok, else expected err_code
  logic [7:0]  pl[$];
  logic [7:0]  raw[$];
  logic [15:0] exp_fcnt = 0;
  logic [15:0] exp_ecnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: otready = 1'b1;
      1: otready = 1'($urandom_range(0, 1));
      default: otready = 1'b0;
    endcase
  end

  // Scoreboard: everything the DUT emits must match the model queues in order.
  always @(negedge clk) begin
    if (!rst) begin
      if (otvalid && otready) begin
        check("out_avail", outq.size() != 0, 1);
        if (outq.size() != 0) check("out_byte", {otlast, otdata}, outq.pop_front());
      end
      check("ok_err_excl", frame_ok & frame_err, 0);
      if (frame_ok || frame_err) begin
        check("evt_avail", evq.size() != 0, 1);
        if (evq.size() != 0) check("evt_code", frame_ok ? 0 : err_code, evq.pop_front());
        if (frame_ok) begin
          exp_fcnt = exp_fcnt + 16'd1;
          check("frame_cnt", frame_cnt, exp_fcnt);
        end else begin
          if (exp_ecnt != 16'hFFFF) exp_ecnt = exp_ecnt + 16'd1;
          check("err_cnt", err_cnt, exp_ecnt);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit want_rdy);
    int n;
    n = 0;
    itvalid = 1'b1;
    itdata  = b;
    @(negedge clk);
    if (want_rdy) check("sof_ready", itready, 1);
    while (!itready && n < 5000) begin
      n++;
      @(negedge clk);
    end
    if (!itready) check("in_stall", itready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    itvalid = 1'b0;
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic send_raw();
    foreach (raw[i]) send_byte(raw[i], 1'b0);
    idle(4);
  endtask

  // Sends SOF, LEN, pl[] and (when compiled in) the checksum; queues expectations.
  task automatic send_frame(input bit bad_chk);
    logic [7:0] c;
    c = 8'(pl.size());
    send_byte(8'hA5, 1'b1);
    send_byte(8'(pl.size()), 1'b0);
    foreach (pl[i]) begin
      outq.push_back({i == pl.size() - 1, pl[i]});
      c = c ^ pl[i];
`ifndef USB_FRAME_CHK_EN
      if (i == pl.size() - 1) evq.push_back(0);
`endif
      send_byte(pl[i], 1'b0);
      if (gaps && i != pl.size() - 1 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 5));
    end
`ifdef USB_FRAME_CHK_EN
    evq.push_back(bad_chk ? 2 : 0);
    send_byte(bad_chk ? c ^ 8'h5A : c, 1'b0);
`else
    if (bad_chk) c = 8'h00;
`endif
  endtask

  task automatic rand_payload(input int len);
    pl.delete();
    for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
  endtask

  initial begin
    logic [15:0] base;
    int n;
    rst = 1; itvalid = 0; itdata = 0; otready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_itready", itready, 1);
    check("rst_otvalid", otvalid, 0);
    check("rst_otlast", otlast, 0);
    check("rst_pulses", {frame_ok, frame_err, err_code}, 0);
    check("rst_cnts", {frame_cnt, err_cnt}, 0);
    @(posedge clk); #1;
    rst = 0;
    idle(2);

    // Good frame A5 03 11 22 33 03
    raw = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    outq.push_back({1'b0, 8'h11}); outq.push_back({1'b0, 8'h22}); outq.push_back({1'b1, 8'h33});
    evq.push_back(0);
    send_raw();
    check("good_fcnt", frame_cnt, 1);

    // Checksum error A5 02 10 20 00
    raw = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
    outq.push_back({1'b0, 8'h10}); outq.push_back({1'b1, 8'h20});
`ifdef USB_FRAME_CHK_EN
    evq.push_back(2);
    send_raw();
    check("chk_ecnt", err_cnt, 1);
    check("chk_fcnt", frame_cnt, 1);
`else
    evq.push_back(0);
    send_raw();
    check("chk_fcnt", frame_cnt, 2);
`endif

    // Garbage, zero length, resync
    raw = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'hA5, 8'h01, 8'h7E, 8'h7F};
    evq.push_back(1);
    outq.push_back({1'b1, 8'h7E});
    evq.push_back(0);
    send_raw();

    // Timeout after 16 idle cycles mid-payload
    send_byte(8'hA5, 1'b1);
    send_byte(8'h04, 1'b0);
    outq.push_back({1'b0, 8'h01});
    evq.push_back(3);
    send_byte(8'h01, 1'b0);
    itvalid = 1'b0;
    repeat (16) @(negedge clk);
    check("tmo_early", frame_err, 0);
    @(negedge clk);
    check("tmo_fire", {frame_err, err_code}, 3'b111);
    @(posedge clk); #1;
    idle(4);

    // Input held valid under 100 cycles of output stall: no timeout
    rdy_mode = 2;
    pl = '{8'hC1, 8'hC2, 8'hC3};
    fork
      send_frame(1'b0);
      begin repeat (100) @(posedge clk); rdy_mode = 1; end
    join
    idle(4);
    check("bp_no_tmo", err_cnt, exp_ecnt);

    // Back-to-back random frames, boundary lengths first
    base = exp_fcnt;
    gaps = 1;
    for (int f = 0; f < 300; f++) begin
      rand_payload(f == 0 ? 1 : (f == 1 ? 255 : $urandom_range(1, 24)));
      send_frame(1'b0);
    end
    gaps = 0;
    check("fcnt300", frame_cnt, base + 16'd300);
    idle(2);

    // Reset mid-payload with one byte held in the output register
    n = 0;
    while ((outq.size() != 0 || evq.size() != 0) && n < 2000) begin n++; @(posedge clk); end
    #1;
    rdy_mode = 2;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h05, 1'b0);
    send_byte(8'h31, 1'b0);
    itvalid = 1'b1; itdata = 8'h32;
    repeat (3) @(posedge clk); #1;
    rst = 1; itvalid = 0;
    @(negedge clk);
    check("mid_rst_otvalid", otvalid, 0);
    check("mid_rst_cnts", {frame_cnt, err_cnt}, 0);
    check("mid_rst_itready", itready, 1);
    exp_fcnt = 0; exp_ecnt = 0;
    @(posedge clk); #1;
    rst = 0;
    rdy_mode = 1;
    idle(2);
    rand_payload(6);
    send_frame(1'b0);
`ifdef USB_FRAME_CHK_EN
    rand_payload(3);
    send_frame(1'b1);
`endif
    idle(2);

    rdy_mode = 0;
    n = 0;
    while ((outq.size() != 0 || evq.size() != 0) && n < 2000) begin n++; @(posedge clk); end
    idle(4);
    check("outq_empty", outq.size(), 0);
    check("evq_empty", evq.size(), 0);
    check("final_fcnt", frame_cnt, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
